frame_buf_reader: RTL and testbench

Read-side scan engine for `frame_buf`, running in the `rd_clk` domain. It generates raster timing counters and drives `frame_buf`'s active-low read enable one pixel at a time. It captures the returned 24-bit pixels and presents them to the display path with aligned `de`, `hsync` and `vsync`. It is the consumer counterpart of the pixel writer on `wr_clk`.

---
 rtl/frame_buf_reader.sv | 223 ++++++++++++++++++++++
 tb/tb_frame_buf_reader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buf_reader.sv
// frame_buf_reader: read-side raster scan engine for frame_buf.
// Generates raster counters, drives the active-low read strobe, captures the
// returned pixels and presents them with aligned de/hsync/vsync/frame_start.
module frame_buf_reader #(
    parameter int DATA_WIDTH = 24,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic                  rd_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fb_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  rd_en_out,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  de,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_start,
    output logic                  underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SCAN
    } state_t;

    state_t state_q, state_d;

    logic [H_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_W-1:0] v_cnt_q, v_cnt_d;

    // Raster position decode for the current cycle
    logic in_scan;
    logic act_now;
    logic hs_now;
    logic vs_now;
    logic fs_now;
    logic end_of_line;
    logic end_of_frame;

    // Three-stage alignment pipeline for the timing flags
    logic act_p1_q, act_p1_d;
    logic act_p2_q, act_p2_d;
    logic hs_p1_q,  hs_p1_d;
    logic hs_p2_q,  hs_p2_d;
    logic vs_p1_q,  vs_p1_d;
    logic vs_p2_q,  vs_p2_d;
    logic fs_p1_q,  fs_p1_d;
    logic fs_p2_q,  fs_p2_d;

    // Registered outputs
    logic                  rd_en_q,       rd_en_d;
    logic [DATA_WIDTH-1:0] pix_data_q,    pix_data_d;
    logic                  de_q,          de_d;
    logic                  hsync_q,       hsync_d;
    logic                  vsync_q,       vsync_d;
    logic                  frame_start_q, frame_start_d;
    logic                  underflow_q,   underflow_d;

    // Decode where the counters sit in the raster; everything is gated by SCAN
    always_comb begin
        in_scan      = (state_q == ST_SCAN);
        act_now      = in_scan && (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
        hs_now       = in_scan && (int'(h_cnt_q) >= H_SYNC_START) && (int'(h_cnt_q) < H_SYNC_END);
        vs_now       = in_scan && (int'(v_cnt_q) >= V_SYNC_START) && (int'(v_cnt_q) < V_SYNC_END);
        fs_now       = in_scan && (h_cnt_q == '0) && (v_cnt_q == '0);
        end_of_line  = (h_cnt_q == H_LAST);
        end_of_frame = end_of_line && (v_cnt_q == V_LAST);
    end

    // Next-state logic: SCAN only re-evaluates enable/fb_ready at end of frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (fb_ready) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (end_of_frame) begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (!fb_ready) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Raster counters run only in SCAN; they wrap to 0 at the end of a frame,
    // which is also the value they hold in IDLE and WAIT
    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (in_scan) begin
            if (end_of_line) begin
                h_cnt_d = '0;
                if (end_of_frame) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
                v_cnt_d = v_cnt_q;
            end
        end
    end

    // Read strobe, flag pipeline, pixel capture and sticky underflow
    always_comb begin
        rd_en_d       = ~act_now;
        act_p1_d      = act_now;
        act_p2_d      = act_p1_q;
        hs_p1_d       = hs_now;
        hs_p2_d       = hs_p1_q;
        vs_p1_d       = vs_now;
        vs_p2_d       = vs_p1_q;
        fs_p1_d       = fs_now;
        fs_p2_d       = fs_p1_q;
        de_d          = act_p2_q;
        hsync_d       = ~hs_p2_q;
        vsync_d       = ~vs_p2_q;
        frame_start_d = fs_p2_q;
        pix_data_d    = '0;
        if (act_p2_q) begin
            pix_data_d = data_in;
        end
        underflow_d   = underflow_q | (act_now & ~fb_ready);
    end

    // State and counter registers with synchronous active-low reset
    always_ff @(posedge rd_clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Pipeline and output registers; reset flushes the pipeline to idle levels
    always_ff @(posedge rd_clk) begin
        if (!reset) begin
            act_p1_q      <= 1'b0;
            act_p2_q      <= 1'b0;
            hs_p1_q       <= 1'b0;
            hs_p2_q       <= 1'b0;
            vs_p1_q       <= 1'b0;
            vs_p2_q       <= 1'b0;
            fs_p1_q       <= 1'b0;
            fs_p2_q       <= 1'b0;
            rd_en_q       <= 1'b1;
            pix_data_q    <= '0;
            de_q          <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            act_p1_q      <= act_p1_d;
            act_p2_q      <= act_p2_d;
            hs_p1_q       <= hs_p1_d;
            hs_p2_q       <= hs_p2_d;
            vs_p1_q       <= vs_p1_d;
            vs_p2_q       <= vs_p2_d;
            fs_p1_q       <= fs_p1_d;
            fs_p2_q       <= fs_p2_d;
            rd_en_q       <= rd_en_d;
            pix_data_q    <= pix_data_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign rd_en_out   = rd_en_q;
    assign pix_data    = pix_data_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_frame_buf_reader.sv
// tb_frame_buf_reader: directed bench for frame_buf_reader on a tiny 8x6 raster
// (H 4/1/2/1, V 3/1/1/1) with a counting frame_buf model behind the read strobe.
module tb_frame_buf_reader;

    logic        rd_clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        fb_ready;
    logic [23:0] data_in;
    logic        rd_en_out;
    logic [23:0] pix_data;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic        underflow;

    logic        model_clear;
    logic [23:0] model_ctr;

    int n_cmp = 0;
    int n_err = 0;

    frame_buf_reader #(
        .DATA_WIDTH(24),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .rd_clk(rd_clk),
        .reset(reset),
        .enable(enable),
        .fb_ready(fb_ready),
        .data_in(data_in),
        .rd_en_out(rd_en_out),
        .pix_data(pix_data),
        .de(de),
        .hsync(hsync),
        .vsync(vsync),
        .frame_start(frame_start),
        .underflow(underflow)
    );

    // Free-running read clock, 10 time units per period
    always #5 rd_clk = ~rd_clk;

    // frame_buf stand-in: each sampled-low read returns the next value 1, 2, 3, ...
    always @(posedge rd_clk) begin
        if (model_clear) begin
            model_ctr <= 24'd0;
            data_in   <= 24'd0;
        end else if (rd_en_out == 1'b0) begin
            model_ctr <= model_ctr + 24'd1;
            data_in   <= model_ctr + 24'd1;
        end
    end

    // Advance to the next falling edge, where outputs are sampled and inputs change
    task automatic tick();
        @(negedge rd_clk);
    endtask

    // Reset held low for three cycles with enable high
    task automatic test_reset();
        reset       = 1'b0;
        enable      = 1'b1;
        fb_ready    = 1'b1;
        model_clear = 1'b1;
        repeat (3) tick();
        n_cmp++; if (rd_en_out !== 1'b1) begin n_err++; $display("[TB] FAIL reset_rd_en: got %b want 1", rd_en_out); end
        n_cmp++; if (hsync !== 1'b1) begin n_err++; $display("[TB] FAIL reset_hsync: got %b want 1", hsync); end
        n_cmp++; if (vsync !== 1'b1) begin n_err++; $display("[TB] FAIL reset_vsync: got %b want 1", vsync); end
        n_cmp++; if (de !== 1'b0) begin n_err++; $display("[TB] FAIL reset_de: got %b want 0", de); end
        n_cmp++; if (pix_data !== 24'h0) begin n_err++; $display("[TB] FAIL reset_pix: got %h want 0", pix_data); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("[TB] FAIL reset_underflow: got %b want 0", underflow); end
        n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("[TB] FAIL reset_frame_start: got %b want 0", frame_start); end
    endtask

    // First frame: start latency, read pattern, pixel order, sync placement
    task automatic test_raster();
        int h;
        int v;
        int p;
        int ph;
        int pv;
        logic exp_de;
        logic exp_rd;
        logic [23:0] exp_pix;
        int rd_lows;
        int de_cnt;
        int hs_lows;
        int vs_lows;
        rd_lows = 0;
        de_cnt  = 0;
        hs_lows = 0;
        vs_lows = 0;
        model_clear = 1'b0;
        reset       = 1'b1;
        tick();
        tick();
        n_cmp++; if (rd_en_out !== 1'b1) begin n_err++; $display("[TB] FAIL start_rd_before: got %b want 1", rd_en_out); end
        tick();
        n_cmp++; if (rd_en_out !== 1'b0) begin n_err++; $display("[TB] FAIL start_first_read: got %b want 0", rd_en_out); end
        tick();
        n_cmp++; if (de !== 1'b0) begin n_err++; $display("[TB] FAIL start_de_before: got %b want 0", de); end
        tick();
        for (int t = 0; t < 48; t++) begin
            if (t > 0) tick();
            h = t % 8;
            v = t / 8;
            exp_de  = (h < 4) && (v < 3);
            exp_pix = exp_de ? 24'(v * 4 + h + 1) : 24'h0;
            p  = (t + 2) % 48;
            ph = p % 8;
            pv = p / 8;
            exp_rd = !((ph < 4) && (pv < 3));
            n_cmp++; if (de !== exp_de) begin n_err++; $display("[TB] FAIL raster_de t=%0d: got %b want %b", t, de, exp_de); end
            n_cmp++; if (pix_data !== exp_pix) begin n_err++; $display("[TB] FAIL raster_pix t=%0d: got %h want %h", t, pix_data, exp_pix); end
            n_cmp++; if (rd_en_out !== exp_rd) begin n_err++; $display("[TB] FAIL raster_rd_en t=%0d: got %b want %b", t, rd_en_out, exp_rd); end
            n_cmp++; if (hsync !== !((h >= 5) && (h < 7))) begin n_err++; $display("[TB] FAIL raster_hsync t=%0d: got %b want %b", t, hsync, !((h >= 5) && (h < 7))); end
            n_cmp++; if (vsync !== (v != 4)) begin n_err++; $display("[TB] FAIL raster_vsync t=%0d: got %b want %b", t, vsync, (v != 4)); end
            n_cmp++; if (frame_start !== (t == 0)) begin n_err++; $display("[TB] FAIL raster_frame_start t=%0d: got %b want %b", t, frame_start, (t == 0)); end
            if (rd_en_out === 1'b0) rd_lows++;
            if (de === 1'b1) de_cnt++;
            if (hsync === 1'b0) hs_lows++;
            if (vsync === 1'b0) vs_lows++;
        end
        n_cmp++; if (rd_lows != 12) begin n_err++; $display("[TB] FAIL raster_read_count: got %0d want 12", rd_lows); end
        n_cmp++; if (de_cnt != 12) begin n_err++; $display("[TB] FAIL raster_de_count: got %0d want 12", de_cnt); end
        n_cmp++; if (hs_lows != 12) begin n_err++; $display("[TB] FAIL raster_hsync_count: got %0d want 12", hs_lows); end
        n_cmp++; if (vs_lows != 8) begin n_err++; $display("[TB] FAIL raster_vsync_count: got %0d want 8", vs_lows); end
    endtask

    // fb_ready low at end of frame parks the engine in WAIT; raising it restarts
    task automatic test_flow_control();
        logic found;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (frame_start === 1'b1) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_err++; $display("[TB] FAIL flow_frame2_start: got none want pulse within 20 cycles"); end
        for (int t = 1; t <= 30; t++) tick();
        fb_ready = 1'b0;
        for (int t = 31; t <= 75; t++) begin
            tick();
            n_cmp++; if (rd_en_out !== 1'b1) begin n_err++; $display("[TB] FAIL flow_wait_rd_en t=%0d: got %b want 1", t, rd_en_out); end
            n_cmp++; if (de !== 1'b0) begin n_err++; $display("[TB] FAIL flow_wait_de t=%0d: got %b want 0", t, de); end
        end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("[TB] FAIL flow_no_underflow: got %b want 0", underflow); end
        fb_ready = 1'b1;
        tick();
        n_cmp++; if (rd_en_out !== 1'b1) begin n_err++; $display("[TB] FAIL flow_entry_rd_en: got %b want 1", rd_en_out); end
        tick();
        n_cmp++; if (rd_en_out !== 1'b0) begin n_err++; $display("[TB] FAIL flow_first_read: got %b want 0", rd_en_out); end
        tick();
        n_cmp++; if (de !== 1'b0) begin n_err++; $display("[TB] FAIL flow_de_before: got %b want 0", de); end
        tick();
        n_cmp++; if (de !== 1'b1) begin n_err++; $display("[TB] FAIL flow_first_de: got %b want 1", de); end
        n_cmp++; if (frame_start !== 1'b1) begin n_err++; $display("[TB] FAIL flow_frame_start: got %b want 1", frame_start); end
        n_cmp++; if (pix_data !== 24'd25) begin n_err++; $display("[TB] FAIL flow_first_pix: got %0d want 25", pix_data); end
    endtask

    // enable dropped at the 5th pixel: the frame finishes in full, then IDLE
    task automatic test_graceful_stop();
        logic [23:0] exp_pix;
        int de_cnt;
        int hs_lows;
        int vs_lows;
        hs_lows = 0;
        vs_lows = 0;
        for (int t = 1; t <= 8; t++) tick();
        n_cmp++; if (pix_data !== 24'd29) begin n_err++; $display("[TB] FAIL stop_pix5: got %0d want 29", pix_data); end
        enable  = 1'b0;
        exp_pix = 24'd30;
        de_cnt  = 1;
        for (int t = 9; t <= 47; t++) begin
            tick();
            if (de === 1'b1) begin
                de_cnt++;
                n_cmp++; if (pix_data !== exp_pix) begin n_err++; $display("[TB] FAIL stop_pix t=%0d: got %0d want %0d", t, pix_data, exp_pix); end
                exp_pix = exp_pix + 24'd1;
            end
            if (hsync === 1'b0) hs_lows++;
            if (vsync === 1'b0) vs_lows++;
        end
        n_cmp++; if (de_cnt != 8) begin n_err++; $display("[TB] FAIL stop_de_count: got %0d want 8", de_cnt); end
        n_cmp++; if (hs_lows != 10) begin n_err++; $display("[TB] FAIL stop_hsync_count: got %0d want 10", hs_lows); end
        n_cmp++; if (vs_lows != 8) begin n_err++; $display("[TB] FAIL stop_vsync_count: got %0d want 8", vs_lows); end
        for (int t = 48; t <= 67; t++) begin
            tick();
            n_cmp++; if (rd_en_out !== 1'b1) begin n_err++; $display("[TB] FAIL stop_idle_rd_en t=%0d: got %b want 1", t, rd_en_out); end
            n_cmp++; if (de !== 1'b0) begin n_err++; $display("[TB] FAIL stop_idle_de t=%0d: got %b want 0", t, de); end
            n_cmp++; if (hsync !== 1'b1 || vsync !== 1'b1) begin n_err++; $display("[TB] FAIL stop_idle_sync t=%0d: got %b%b want 11", t, hsync, vsync); end
            n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("[TB] FAIL stop_idle_frame_start t=%0d: got %b want 0", t, frame_start); end
        end
        n_cmp++; if (model_ctr !== 24'd36) begin n_err++; $display("[TB] FAIL stop_total_reads: got %0d want 36", model_ctr); end
    endtask

    // fb_ready dropped while reading pixel 6 sets sticky underflow; reset mid-line clears all
    task automatic test_underflow_abort();
        enable   = 1'b1;
        fb_ready = 1'b1;
        for (int i = 1; i <= 5; i++) tick();
        n_cmp++; if (de !== 1'b1 || frame_start !== 1'b1) begin n_err++; $display("[TB] FAIL uf_frame_start: got de=%b fs=%b want 1 1", de, frame_start); end
        n_cmp++; if (pix_data !== 24'd37) begin n_err++; $display("[TB] FAIL uf_first_pix: got %0d want 37", pix_data); end
        for (int t = 1; t <= 6; t++) tick();
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("[TB] FAIL uf_before: got %b want 0", underflow); end
        fb_ready = 1'b0;
        tick();
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("[TB] FAIL uf_set: got %b want 1", underflow); end
        fb_ready = 1'b1;
        tick();
        n_cmp++; if (pix_data !== 24'd41) begin n_err++; $display("[TB] FAIL uf_pix5: got %0d want 41", pix_data); end
        tick();
        n_cmp++; if (pix_data !== 24'd42) begin n_err++; $display("[TB] FAIL uf_pix6: got %0d want 42", pix_data); end
        for (int t = 10; t <= 17; t++) begin
            tick();
            n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("[TB] FAIL uf_sticky t=%0d: got %b want 1", t, underflow); end
        end
        n_cmp++; if (de !== 1'b1 || pix_data !== 24'd46) begin n_err++; $display("[TB] FAIL uf_scan_continues: got de=%b pix=%0d want 1 46", de, pix_data); end
        reset = 1'b0;
        tick();
        n_cmp++; if (rd_en_out !== 1'b1) begin n_err++; $display("[TB] FAIL abort_rd_en: got %b want 1", rd_en_out); end
        n_cmp++; if (hsync !== 1'b1) begin n_err++; $display("[TB] FAIL abort_hsync: got %b want 1", hsync); end
        n_cmp++; if (vsync !== 1'b1) begin n_err++; $display("[TB] FAIL abort_vsync: got %b want 1", vsync); end
        n_cmp++; if (de !== 1'b0) begin n_err++; $display("[TB] FAIL abort_de: got %b want 0", de); end
        n_cmp++; if (pix_data !== 24'h0) begin n_err++; $display("[TB] FAIL abort_pix: got %h want 0", pix_data); end
        n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("[TB] FAIL abort_frame_start: got %b want 0", frame_start); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("[TB] FAIL abort_underflow: got %b want 0", underflow); end
        reset = 1'b1;
        tick();
    endtask

    // Scenario sequence
    initial begin
        reset       = 1'b0;
        enable      = 1'b0;
        fb_ready    = 1'b0;
        model_clear = 1'b1;
        test_reset();
        test_raster();
        test_flow_control();
        test_graceful_stop();
        test_underflow_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
